// File: rtl/pit_pkg.sv
// Shared widths, response codes and FSM encoding for the PIT lookup requester.
package pit_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;
  localparam int KEY_W    = PREFIX_W + LEN_W;

  localparam logic [1:0] RSP_HIT     = 2'd0;
  localparam logic [1:0] RSP_REJECT  = 2'd1;
  localparam logic [1:0] RSP_TIMEOUT = 2'd2;

  // Consecutive data grants allowed before a waiting interest is served.
  localparam logic [2:0] ARB_DATA_RUN = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } pit_state_e;

  // A hit wins when the table raises hit and miss together.
  function automatic logic [1:0] pit_resp_code(input logic hit);
    return hit ? RSP_HIT : RSP_REJECT;
  endfunction

endpackage

// File: rtl/pit_req_fifo.sv
// Synchronous show-ahead request FIFO; accepts a push on full when a pop
// happens in the same cycle.
module pit_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             wr_en, rd_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/pit_lookup_requester.sv
// Arbitrates interest/data requests onto the PIT hash table and returns results.
// Optional WAIT timeout: define PIT_REQ_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a queued request; pops and latches the winner
// ISSUE | first cycle the key and strobe are presented to the PIT
// WAIT  | strobe held until hit/miss (or timeout when enabled)
// RESP  | result held on the rsp channel until rsp_ready
module pit_lookup_requester
  import pit_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                int_valid,
  output logic                int_ready,
  input  logic [PREFIX_W-1:0] int_prefix,
  input  logic [LEN_W-1:0]    int_len,
  input  logic                dat_valid,
  output logic                dat_ready,
  input  logic [PREFIX_W-1:0] dat_prefix,
  input  logic [LEN_W-1:0]    dat_len,
  output logic [PREFIX_W-1:0] pit_prefix,
  output logic [LEN_W-1:0]    pit_len,
  output logic                pit_out_bit,
  output logic                pit_prefix_ready,
  input  logic                pit_in_bit,
  input  logic                pit_rejected,
  input  logic [63:0]         pit_table_entry,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_code,
  output logic [63:0]         rsp_entry,
  output logic                rsp_is_data
);

  logic [KEY_W-1:0] int_head, dat_head;
  logic             int_empty, int_full, dat_empty, dat_full;
  logic             int_pop, dat_pop, int_first;

  pit_state_e       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             is_data_q, is_data_d;
  logic [2:0]       streak_q, streak_d;
  logic [1:0]       rsp_code_q, rsp_code_d;
  logic [63:0]      rsp_entry_q, rsp_entry_d;

  pit_req_fifo #(.WIDTH(KEY_W), .DEPTH(FIFO_DEPTH)) u_int_fifo (
    .clk_i(clk), .rst_i(rst), .push_i(int_valid && int_ready),
    .data_i({int_prefix, int_len}), .pop_i(int_pop), .data_o(int_head),
    .empty_o(int_empty), .full_o(int_full)
  );

  pit_req_fifo #(.WIDTH(KEY_W), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
    .clk_i(clk), .rst_i(rst), .push_i(dat_valid && dat_ready),
    .data_i({dat_prefix, dat_len}), .pop_i(dat_pop), .data_o(dat_head),
    .empty_o(dat_empty), .full_o(dat_full)
  );

  assign int_ready = !int_full;
  assign dat_ready = !dat_full;
  assign int_first = !int_empty && (dat_empty || streak_q == ARB_DATA_RUN);

`ifdef PIT_REQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^{TIMEOUT_CYCLES, RSP_TIMEOUT};
`endif

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    is_data_d   = is_data_q;
    streak_d    = streak_q;
    rsp_code_d  = rsp_code_q;
    rsp_entry_d = rsp_entry_q;
    int_pop     = 1'b0;
    dat_pop     = 1'b0;
`ifdef PIT_REQ_TIMEOUT_EN
    tmr_d       = tmr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (int_first) begin
          int_pop   = 1'b1;
          key_d     = int_head;
          is_data_d = 1'b0;
          streak_d  = '0;
          state_d   = ST_ISSUE;
        end else if (!dat_empty) begin
          dat_pop   = 1'b1;
          key_d     = dat_head;
          is_data_d = 1'b1;
          if (streak_q != ARB_DATA_RUN) streak_d = streak_q + 3'd1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef PIT_REQ_TIMEOUT_EN
        tmr_d   = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (pit_in_bit || pit_rejected) begin
          rsp_code_d  = pit_resp_code(pit_in_bit);
          rsp_entry_d = pit_in_bit ? pit_table_entry : '0;
          state_d     = ST_RESP;
        end
`ifdef PIT_REQ_TIMEOUT_EN
        else if (tmr_q == '0) begin
          rsp_code_d  = RSP_TIMEOUT;
          rsp_entry_d = '0;
          state_d     = ST_RESP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      is_data_q   <= 1'b0;
      streak_q    <= '0;
      rsp_code_q  <= '0;
      rsp_entry_q <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      is_data_q   <= is_data_d;
      streak_q    <= streak_d;
      rsp_code_q  <= rsp_code_d;
      rsp_entry_q <= rsp_entry_d;
    end
  end

  // Strobes decode straight from the state register so reset kills them at once.
  assign pit_prefix       = key_q[KEY_W-1:LEN_W];
  assign pit_len          = key_q[LEN_W-1:0];
  assign pit_prefix_ready = (state_q == ST_ISSUE || state_q == ST_WAIT) && is_data_q;
  assign pit_out_bit      = (state_q == ST_ISSUE || state_q == ST_WAIT) && !is_data_q;
  assign rsp_valid        = (state_q == ST_RESP);
  assign rsp_code         = rsp_code_q;
  assign rsp_entry        = rsp_entry_q;
  assign rsp_is_data      = is_data_q;

endmodule

// File: tb/tb_pit_lookup_requester.sv
// Directed self-checking bench for pit_lookup_requester (timeout case follows PIT_REQ_TIMEOUT_EN).
module tb_pit_lookup_requester;
  import pit_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        int_valid, int_ready, dat_valid, dat_ready;
  logic [63:0] int_prefix, dat_prefix, pit_prefix, pit_table_entry, rsp_entry;
  logic [5:0]  int_len, dat_len, pit_len;
  logic        pit_out_bit, pit_prefix_ready, pit_in_bit, pit_rejected;
  logic        rsp_valid, rsp_ready, rsp_is_data;
  logic [1:0]  rsp_code;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pit_lookup_requester #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .int_valid(int_valid), .int_ready(int_ready), .int_prefix(int_prefix), .int_len(int_len),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_prefix(dat_prefix), .dat_len(dat_len),
    .pit_prefix(pit_prefix), .pit_len(pit_len),
    .pit_out_bit(pit_out_bit), .pit_prefix_ready(pit_prefix_ready),
    .pit_in_bit(pit_in_bit), .pit_rejected(pit_rejected), .pit_table_entry(pit_table_entry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
    .rsp_entry(rsp_entry), .rsp_is_data(rsp_is_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_int(input logic [63:0] p, input logic [5:0] l);
    int_valid = 1'b1; int_prefix = p; int_len = l;
    tick();
    int_valid = 1'b0;
  endtask

  task automatic push_dat(input logic [63:0] p, input logic [5:0] l);
    dat_valid = 1'b1; dat_prefix = p; dat_len = l;
    tick();
    dat_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    bit          stable, seen, strobe_held, saw_full, prev_busy, prev_ready, busy_now;
    bit          new_i, new_d;
    logic        grants [12];
    int          ng, cyc, occ, rdy_bad;

    rst = 1'b1;
    int_valid = 1'b0; int_prefix = '0; int_len = '0;
    dat_valid = 1'b0; dat_prefix = '0; dat_len = '0;
    pit_in_bit = 1'b0; pit_rejected = 1'b0; pit_table_entry = '0;
    rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_int_ready", int_ready, 1);
    chk("rst_dat_ready", dat_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_out_bit", pit_out_bit, 0);
    chk("rst_pref_rdy", pit_prefix_ready, 0);
    chk("rst_prefix", pit_prefix, 0);

    // interest insert answered with a hit
    push_int(64'h1234, 6'd8);
    chk("i_idle_out_bit", pit_out_bit, 0);
    tick();
    chk("i_issue_out_bit", pit_out_bit, 1);
    chk("i_issue_pref_rdy", pit_prefix_ready, 0);
    chk("i_prefix", pit_prefix, 64'h1234);
    chk("i_len", pit_len, 8);
    tick();
    tick();
    chk("i_wait_out_bit", pit_out_bit, 1);
    pit_in_bit = 1'b1; pit_table_entry = 64'h8000_0000_0000_0400;
    tick();
    pit_in_bit = 1'b0; pit_table_entry = '0;
    chk("i_rsp_valid", rsp_valid, 1);
    chk("i_rsp_code", rsp_code, 0);
    chk("i_rsp_entry", rsp_entry, 64'h8000_0000_0000_0400);
    chk("i_rsp_is_data", rsp_is_data, 0);
    chk("i_rsp_out_bit", pit_out_bit, 0);
    handshake();
    chk("i_done_rsp_valid", rsp_valid, 0);

    // data lookup rejected, response held while rsp_ready is low
    push_dat(64'hABCD_0000_1111_2222, 6'd63);
    chk("d_idle_pref_rdy", pit_prefix_ready, 0);
    tick();
    chk("d_issue_pref_rdy", pit_prefix_ready, 1);
    chk("d_issue_out_bit", pit_out_bit, 0);
    chk("d_prefix", pit_prefix, 64'hABCD_0000_1111_2222);
    tick();
    chk("d_wait_pref_rdy", pit_prefix_ready, 1);
    pit_rejected = 1'b1; pit_table_entry = 64'hDEAD_BEEF;
    tick();
    pit_rejected = 1'b0;
    chk("d_rsp_valid", rsp_valid, 1);
    chk("d_rsp_code", rsp_code, 1);
    chk("d_rsp_entry", rsp_entry, 0);
    chk("d_rsp_is_data", rsp_is_data, 1);
    chk("d_rsp_pref_rdy", pit_prefix_ready, 0);
    pit_in_bit = 1'b1; pit_table_entry = 64'h5555_AAAA;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(rsp_valid === 1'b1 && rsp_code === 2'd1 && rsp_entry === 64'h0 &&
            rsp_is_data === 1'b1 && pit_prefix_ready === 1'b0)) stable = 1'b0;
    end
    pit_in_bit = 1'b0; pit_table_entry = '0;
    chk("d_hold_stable", stable, 1);
    handshake();
    chk("d_done_rsp_valid", rsp_valid, 0);

    // hit and miss together count as a hit
    push_dat(64'h55, 6'd1);
    tick();
    tick();
    pit_in_bit = 1'b1; pit_rejected = 1'b1; pit_table_entry = 64'h77;
    tick();
    pit_in_bit = 1'b0; pit_rejected = 1'b0; pit_table_entry = '0;
    chk("b_rsp_code", rsp_code, 0);
    chk("b_rsp_entry", rsp_entry, 64'h77);
    handshake();

    // reset while waiting, with a second request still queued
    push_int(64'hF00D, 6'd5);
    push_int(64'hBEEF, 6'd6);
    chk("r_issue_out_bit", pit_out_bit, 1);
    chk("r_issue_prefix", pit_prefix, 64'hF00D);
    tick();
    chk("r_wait_out_bit", pit_out_bit, 1);
    #2 rst = 1'b1;
    #1;
    chk("r_async_out_bit", pit_out_bit, 0);
    chk("r_async_pref_rdy", pit_prefix_ready, 0);
    chk("r_async_rsp_valid", rsp_valid, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("r_int_ready", int_ready, 1);
    chk("r_dat_ready", dat_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid || pit_out_bit || pit_prefix_ready) seen = 1'b1;
    end
    chk("r_no_activity", seen, 0);

    // both channels saturated: D,D,D,D,I repeating
    int_valid = 1'b1; int_prefix = 64'h11; int_len = 6'd1;
    dat_valid = 1'b1; dat_prefix = 64'h22; dat_len = 6'd2;
    rsp_ready = 1'b1;
    ng = 0; cyc = 0; occ = 0; rdy_bad = 0; saw_full = 1'b0;
    prev_busy = 1'b0; prev_ready = int_ready;
    while (ng < 12 && cyc < 400) begin
      tick();
      cyc++;
      busy_now = pit_out_bit || pit_prefix_ready;
      new_i = pit_out_bit && !prev_busy;
      new_d = pit_prefix_ready && !prev_busy;
      occ = occ + (prev_ready ? 1 : 0) - (new_i ? 1 : 0);
      if (occ == DEPTH) saw_full = 1'b1;
      if (int_ready !== (occ != DEPTH)) rdy_bad++;
      if (new_i || new_d) begin
        grants[ng] = new_d;
        ng++;
      end
      pit_in_bit = busy_now; pit_table_entry = 64'h1;
      prev_busy = busy_now;
      prev_ready = int_ready;
    end
    chk("arb_grant_count", ng, 12);
    for (int k = 0; k < ng; k++)
      chk($sformatf("arb_grant%0d_is_data", k), grants[k], (k % 5 == 4) ? 1'b0 : 1'b1);
    chk("arb_int_ready_vs_occ", rdy_bad, 0);
    chk("arb_int_fifo_filled", saw_full, 1);
    int_valid = 1'b0; dat_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      pit_in_bit = pit_out_bit || pit_prefix_ready;
    end
    pit_in_bit = 1'b0; pit_table_entry = '0; rsp_ready = 1'b0;
    tick();
    chk("drain_rsp_valid", rsp_valid, 0);
    chk("drain_int_ready", int_ready, 1);
    chk("drain_dat_ready", dat_ready, 1);

    // silent PIT
    push_dat(64'hC0FFEE, 6'd2);
    tick();
    chk("t_issue_pref_rdy", pit_prefix_ready, 1);
`ifdef PIT_REQ_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) tick();
    chk("t_before_rsp_valid", rsp_valid, 0);
    chk("t_before_pref_rdy", pit_prefix_ready, 1);
    tick();
    chk("t_rsp_valid", rsp_valid, 1);
    chk("t_rsp_code", rsp_code, 2);
    chk("t_rsp_entry", rsp_entry, 0);
    chk("t_rsp_is_data", rsp_is_data, 1);
    chk("t_rsp_pref_rdy", pit_prefix_ready, 0);
    handshake();
`else
    seen = 1'b0; strobe_held = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
      if (!pit_prefix_ready) strobe_held = 1'b0;
    end
    chk("t_no_rsp", seen, 0);
    chk("t_strobe_held", strobe_held, 1);
    pit_rejected = 1'b1;
    tick();
    pit_rejected = 1'b0;
    chk("t_late_rsp_valid", rsp_valid, 1);
    chk("t_late_rsp_code", rsp_code, 1);
    handshake();
`endif
    chk("t_done_rsp_valid", rsp_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
